// File: rtl/alu_pipe.sv
// Pipelined ALU with a registered result, valid/ready handshakes and an architectural NZCV flag register.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier for op C.
module alu_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             busy
);

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_ORR = 4'h8;
   localparam logic [3:0] OP_MOV = 4'h9;
   localparam logic [3:0] OP_BIC = 4'hA;
   localparam logic [3:0] OP_MVN = 4'hB;

   logic             accept;
   logic [WIDTH-1:0] opx;
   logic [WIDTH-1:0] opy;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic             alu_v;
   logic [WIDTH-1:0] alu_res;
   logic             is_arith;
   logic             is_logic;

   logic             done;
   logic [WIDTH-1:0] done_res;
   logic             done_nz;
   logic             done_cv;

   assign accept = in_valid && in_ready;

   // Every arithmetic op is folded onto one adder as x + y + cin, with y inverted for subtracts.
   always_comb begin
      opx      = a;
      opy      = b;
      cin      = 1'b0;
      is_arith = 1'b0;
      is_logic = 1'b0;
      alu_res  = '0;
      case (op)
         OP_SUB: begin opy = ~b; cin = 1'b1; is_arith = 1'b1; end
         OP_RSB: begin opx = b; opy = ~a; cin = 1'b1; is_arith = 1'b1; end
         OP_ADD: is_arith = 1'b1;
         OP_ADC: begin cin = flag_c; is_arith = 1'b1; end
         OP_SBC: begin opy = ~b; cin = flag_c; is_arith = 1'b1; end
         OP_RSC: begin opx = b; opy = ~a; cin = flag_c; is_arith = 1'b1; end
         OP_AND, OP_EOR, OP_ORR, OP_MOV, OP_BIC, OP_MVN: is_logic = 1'b1;
         default: ;
      endcase
      sum   = {1'b0, opx} + {1'b0, opy} + {{WIDTH{1'b0}}, cin};
      alu_v = (opx[WIDTH-1] == opy[WIDTH-1]) && (sum[WIDTH-1] != opx[WIDTH-1]);
      case (op)
         OP_AND: alu_res = a & b;
         OP_EOR: alu_res = a ^ b;
         OP_ORR: alu_res = a | b;
         OP_MOV: alu_res = b;
         OP_BIC: alu_res = a & ~b;
         OP_MVN: alu_res = ~b;
         default: if (is_arith) alu_res = sum[WIDTH-1:0];
      endcase
   end

`ifdef ALU_PIPE_MUL_EN
   localparam int CW = $clog2(WIDTH);
   localparam logic [3:0] OP_MUL = 4'hC;

   typedef enum logic {S_IDLE, S_MUL} state_t;
   state_t state, state_next;

   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH-1:0] mul_sum;
   logic [CW-1:0]    mul_cnt;
   logic             mul_sf;
   logic             is_mul;
   logic             mul_last;

   assign is_mul   = (op == OP_MUL);
   assign mul_last = (state == S_MUL) && (mul_cnt == CW'(WIDTH - 1));
   assign mul_sum  = mul_acc + (mul_b[0] ? mul_a : '0);
   assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
   assign busy     = (state == S_MUL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (accept && is_mul) state_next = S_MUL;
         S_MUL:   if (mul_last) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // One shift-add step per cycle; the final step is folded into the completion value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_a   <= '0;
         mul_b   <= '0;
         mul_acc <= '0;
         mul_cnt <= '0;
         mul_sf  <= 1'b0;
      end else if (accept && is_mul) begin
         mul_a   <= a;
         mul_b   <= b;
         mul_acc <= '0;
         mul_cnt <= '0;
         mul_sf  <= set_flags;
      end else if (state == S_MUL) begin
         mul_acc <= mul_sum;
         mul_a   <= mul_a << 1;
         mul_b   <= mul_b >> 1;
         mul_cnt <= mul_cnt + 1'b1;
      end
   end

   always_comb begin
      done     = accept && !is_mul;
      done_res = alu_res;
      done_nz  = set_flags && (is_arith || is_logic);
      done_cv  = set_flags && is_arith;
      if (mul_last) begin
         done     = 1'b1;
         done_res = mul_sum;
         done_nz  = mul_sf;
         done_cv  = 1'b0;
      end
   end
`else
   assign in_ready = !out_valid || out_ready;
   assign busy     = 1'b0;

   always_comb begin
      done     = accept;
      done_res = alu_res;
      done_nz  = set_flags && (is_arith || is_logic);
      done_cv  = set_flags && is_arith;
   end
`endif

   // A completion always wins over a drain, so drain-and-accept keeps out_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         out_valid <= 1'b0;
         flag_n    <= 1'b0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         flag_v    <= 1'b0;
      end else if (done) begin
         result    <= done_res;
         out_valid <= 1'b1;
         if (done_nz) begin
            flag_n <= done_res[WIDTH-1];
            flag_z <= (done_res == '0);
         end
         if (done_cv) begin
            flag_c <= sum[WIDTH];
            flag_v <= alu_v;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed, table-driven bench for alu_pipe (WIDTH=32), with hand sequences for chaining,
// backpressure, MUL timing (when ALU_PIPE_MUL_EN is defined) and reset abort.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        set_flags;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        flag_n, flag_z, flag_c, flag_v;
   logic        busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        sf;
      logic [31:0] res;
      logic [3:0]  nzcv;
   } vec_t;

   vec_t vecs[17];

   alu_pipe #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .set_flags (set_flags),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_n    (flag_n),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_v    (flag_v),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] nzcv();
      return {28'd0, flag_n, flag_z, flag_c, flag_v};
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Presents one op at a negedge, expects it to be accepted at the next posedge.
   task automatic apply_stimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic sf);
      @(negedge clk);
      in_valid  = 1'b1;
      op        = o;
      a         = x;
      b         = y;
      set_flags = sf;
      #1 check_output("in_ready before accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   initial begin
      int cnt;
      logic seen;

      vecs[0]  = '{4'h4, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 4'b1001};
      vecs[1]  = '{4'h2, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 4'b0110};
      vecs[2]  = '{4'h5, 32'h00000001, 32'h00000001, 1'b1, 32'h00000003, 4'b0000};
      vecs[3]  = '{4'h2, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 4'b0011};
      vecs[4]  = '{4'h0, 32'h000000F0, 32'h0000000F, 1'b1, 32'h00000000, 4'b0111};
      vecs[5]  = '{4'h8, 32'h000000F0, 32'h0000000F, 1'b0, 32'h000000FF, 4'b0111};
      vecs[6]  = '{4'h6, 32'h0000000A, 32'h00000003, 1'b1, 32'h00000007, 4'b0010};
      vecs[7]  = '{4'h3, 32'h0000000A, 32'h00000003, 1'b1, 32'hFFFFFFF9, 4'b1000};
      vecs[8]  = '{4'h7, 32'h00000001, 32'h00000005, 1'b1, 32'h00000003, 4'b0010};
      vecs[9]  = '{4'h6, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0110};
      vecs[10] = '{4'h1, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 32'hF00FF00F, 4'b1010};
      vecs[11] = '{4'h9, 32'h12345678, 32'h00000000, 1'b1, 32'h00000000, 4'b0110};
      vecs[12] = '{4'hA, 32'hFFFFFFFF, 32'h0000FFFF, 1'b1, 32'hFFFF0000, 4'b1010};
      vecs[13] = '{4'hB, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 4'b1010};
      vecs[14] = '{4'hE, 32'h00000001, 32'h00000002, 1'b1, 32'h00000000, 4'b1010};
      vecs[15] = '{4'h4, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b1010};
      vecs[16] = '{4'h5, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b0110};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 4'h0;
      a         = '0;
      b         = '0;
      set_flags = 1'b0;
      out_ready = 1'b1;

      #12;
      check_output("reset out_valid", {31'd0, out_valid}, 32'd0);
      check_output("reset result", result, 32'd0);
      check_output("reset flags", nzcv(), 32'd0);
      check_output("reset busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_output("in_ready after reset", {31'd0, in_ready}, 32'd1);

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf);
         @(negedge clk);
         check_output($sformatf("vec%0d result", i), result, vecs[i].res);
         check_output($sformatf("vec%0d nzcv", i), nzcv(), {28'd0, vecs[i].nzcv});
         check_output($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      end

      // SUB then ADC accepted on consecutive edges; ADC must see the fresh carry.
      @(negedge clk);
      in_valid = 1'b1; op = 4'h2; a = 32'd5; b = 32'd5; set_flags = 1'b1;
      @(negedge clk);
      check_output("chain sub result", result, 32'd0);
      check_output("chain sub nzcv", nzcv(), 32'b0110);
      check_output("chain in_ready", {31'd0, in_ready}, 32'd1);
      op = 4'h5; a = 32'd1; b = 32'd1;
      @(negedge clk);
      in_valid = 1'b0;
      check_output("chain adc result", result, 32'd3);
      check_output("chain adc nzcv", nzcv(), 32'b0000);

      // Backpressure: result held three cycles, then drain and accept in the same cycle.
      apply_stimulus(4'h4, 32'd2, 32'd3, 1'b1);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; op = 4'h8; a = 32'h30; b = 32'h0C; set_flags = 1'b0;
         check_output($sformatf("hold%0d result", i), result, 32'd5);
         check_output($sformatf("hold%0d nzcv", i), nzcv(), 32'b0000);
         check_output($sformatf("hold%0d in_ready", i), {31'd0, in_ready}, 32'd0);
         check_output($sformatf("hold%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      #1 check_output("release in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check_output("drain+accept result", result, 32'h3C);
      check_output("drain+accept out_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      check_output("drained out_valid", {31'd0, out_valid}, 32'd0);

`ifdef ALU_PIPE_MUL_EN
      apply_stimulus(4'hC, 32'h00010001, 32'h00010001, 1'b1);
      @(negedge clk);
      check_output("mul in_ready while busy", {31'd0, in_ready}, 32'd0);
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check_output("mul busy cycles", cnt, 32'd32);
      check_output("mul out_valid", {31'd0, out_valid}, 32'd1);
      check_output("mul result", result, 32'h00020001);
      check_output("mul nzcv", nzcv(), 32'b0000);

      apply_stimulus(4'hC, 32'h00000003, 32'h00000005, 1'b1);
      repeat (10) @(negedge clk);
      check_output("mul busy before abort", {31'd0, busy}, 32'd1);
`else
      apply_stimulus(4'hC, 32'h00000003, 32'h00000005, 1'b1);
      @(negedge clk);
      check_output("reserved mul result", result, 32'd0);
      check_output("reserved mul nzcv", nzcv(), 32'b0000);
      check_output("reserved mul busy", {31'd0, busy}, 32'd0);
      apply_stimulus(4'h2, 32'h80000000, 32'h00000001, 1'b1);
      @(negedge clk);
`endif
      rst_n = 1'b0;
      #2;
      check_output("abort out_valid", {31'd0, out_valid}, 32'd0);
      check_output("abort busy", {31'd0, busy}, 32'd0);
      check_output("abort flags", nzcv(), 32'd0);
      check_output("abort result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid || busy) seen = 1'b1;
      end
      check_output("no late result", {31'd0, seen}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the combinational datapath ALU. It registers its result and holds an architectural NZCV flag register, so carry-chained ops (ADC/SBC/RSC) read the flag state left by the previous flag-setting op. With the multiply option compiled in, it runs an iterative shift-add multiply. It sits between the decode/register-read stage and writeback in the core, with valid/ready on both sides.

## Interface
- `WIDTH`, 32: operand/result width, ≥ 4
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  block can accept an operation this cycle
- `op`  in  4  operation code (see Operation)
- `a`  in  WIDTH  first operand (Rn)
- `b`  in  WIDTH  second operand (Op2)
- `set_flags`  in  1  update NZCV when this op completes
- `out_valid`  out  1  `result` holds a completed op
- `out_ready`  in  1  consumer takes the result
- `result`  out  WIDTH  registered result
- `flag_n`, `flag_z`, `flag_c`, `flag_v`  out  1 each  architectural flag register
- `busy`  out  1  multi-cycle op in progress

## Operation
- Opcodes:
  - 0 AND, 1 EOR, 2 SUB a−b, 3 RSB b−a
  - 4 ADD, 5 ADC a+b+C, 6 SBC a−b−!C, 7 RSC b−a−!C
  - 8 ORR, 9 MOV b, A BIC a&~b, B MVN ~b
  - C MUL (macro only), D–F reserved
- Subtract forms are computed as x + ~y + cin.
  - cin = 1 for SUB/RSB.
  - cin = `flag_c` for ADC/SBC/RSC, sampled at accept.
- Arithmetic flag update, when `set_flags`:
  - N = result[WIDTH−1]; Z = (result == 0).
  - C = carry out of bit WIDTH−1.
  - V = signed overflow: operands' sign bits equal and result's sign bit differs.
- Logical ops (0,1,8–B) and MUL: update N and Z only; C and V are held.
- Reserved ops, and MUL when the macro is off:
  - complete normally with result 0; flags unchanged regardless of `set_flags`.
- `set_flags` = 0: result is produced; flags are untouched.
- State machine:
  - IDLE: accept on `in_valid && in_ready`. Single-cycle ops go to IDLE with the output register loaded. MUL goes to MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles, then load the output register and return to IDLE.
- Output register:
  - loaded when an op completes; `out_valid` set.
  - cleared when `out_valid && out_ready` and no new completion occurs in the same cycle.
- `in_ready` = (state == IDLE) && (!`out_valid` || `out_ready`).
- `busy` = (state == MUL).
- Inputs are ignored while `in_ready` = 0.

## Timing
- Reset values (async, immediate): `out_valid` 0, `result` 0, all flags 0, state IDLE, `busy` 0. `in_ready` is 1 once reset is released.
- Single-cycle ops:
  - accept at edge k; `result`, `out_valid` and flags are valid after edge k (latency 1).
  - Back-to-back accepts every cycle are possible while `out_ready` = 1.
- Flag chaining: an ADC accepted at edge k+1 sees C written at edge k (no bubble).
- MUL:
  - accepted at edge k; `busy` is high from k to k+WIDTH−1; result is valid after edge k+WIDTH.
  - The result is the low WIDTH bits of a×b.
- Backpressure: while `out_valid` && !`out_ready`, `result` and flags are held stable and `in_ready` = 0.
- Simultaneous drain and accept in one cycle: the output register takes the new result; `out_valid` stays 1.
- Reset asserted mid-MUL: the op is aborted and all state returns to reset values; no partial result is emitted.

## Configuration
- `ALU_PIPE_MUL_EN` defined:
  - op C is the iterative multiplier; the MUL state and `busy` are live.
- Undefined:
  - no multiplier logic is built; op C behaves as reserved.
  - `busy` is tied 0; state stays IDLE.

## Test plan
- Flag-setting ADD, WIDTH=32, a=0x7FFFFFFF, b=1 -> result 0x80000000, N=1 Z=0 C=0 V=1, one cycle after accept.
- SUB a=5, b=5, `set_flags` -> result 0, Z=1 C=1; next cycle ADC a=1, b=1 -> result 3, C=0, with no stall.
- AND a=0xF0, b=0x0F with C=1 V=1 preset -> result 0, Z=1, C=1 and V=1 unchanged. Same op with `set_flags`=0 -> flags unchanged.
- Hold `out_ready`=0 for 3 cycles after an ADD -> `result` and flags stable, `in_ready`=0. Release -> drain and a new accept happen in the same cycle.
- With `ALU_PIPE_MUL_EN`, MUL a=0x10001, b=0x10001 -> `busy` for 32 cycles, then result 0x00020001, N=0 Z=0.
- Reset pulse at cycle 10 of a MUL -> `out_valid`=0 with no late result. Without the macro, op C -> result 0, flags unchanged.
